// File: rtl/demux_router_8ch.sv
// Packet demux: routes each packet to one of 8 channels by destination or round-robin.
// A single registered output buffer feeds a shared data bus with one-hot valids.
module demux_router_8ch #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_dest,
  input  logic              in_last,
  input  logic              cfg_rr,
  input  logic [7:0]        ch_en,
  output logic [7:0]        out_valid,
  input  logic [7:0]        out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [7:0]        drop_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DROP
  } state_e;

  state_e            state_q, state_d;
  logic              obuf_v_q, obuf_v_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [2:0]        sel_q, sel_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic       acc;
  logic       drain;
  logic       rr_hit;
  logic [2:0] rr_ch;
  logic       load;
  logic [2:0] load_sel;

  assign drain    = obuf_v_q & out_ready[sel_q];
  assign in_ready = (state_q == DROP) | ~obuf_v_q
                  | out_ready[sel_q];
  assign acc      = in_valid & in_ready;

  // Descending scan so the nearest enabled channel from rr_ptr wins.
  always_comb begin
    logic [2:0] idx;
    rr_hit = 1'b0;
    rr_ch  = rr_ptr_q;
    idx    = rr_ptr_q;
    for (int i = 7; i >= 0; i--) begin
      idx = rr_ptr_q + 3'(i);
      if (ch_en[idx]) begin
        rr_hit = 1'b1;
        rr_ch  = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    obuf_v_d   = obuf_v_q & ~drain;
    data_d     = data_q;
    last_d     = last_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    drop_cnt_d = drop_cnt_q;
    load       = 1'b0;
    load_sel   = sel_q;
    if (acc) begin
      unique case (state_q)
        IDLE: begin
          if (cfg_rr) begin
            load     = rr_hit;
            load_sel = rr_ch;
            if (rr_hit) rr_ptr_d = rr_ch + 3'd1;
          end else begin
            load     = ch_en[in_dest];
            load_sel = in_dest;
          end
          if (load) begin
            state_d = in_last ? IDLE : PASS;
          end else begin
            state_d = in_last ? IDLE : DROP;
            if (drop_cnt_q != 8'hFF)
              drop_cnt_d = drop_cnt_q + 8'd1;
          end
        end
        PASS: begin
          load     = 1'b1;
          load_sel = sel_q;
          if (in_last) state_d = IDLE;
        end
        DROP: begin
          if (in_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (load) begin
      obuf_v_d = 1'b1;
      data_d   = in_data;
      last_d   = in_last;
      sel_d    = load_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      obuf_v_q   <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      sel_q      <= 3'd0;
      rr_ptr_q   <= 3'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      obuf_v_q   <= obuf_v_d;
      data_q     <= data_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_valid = obuf_v_q ? (8'h01 << sel_q) : 8'h00;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign drop_cnt  = drop_cnt_q;
  assign busy      = (state_q != IDLE) | obuf_v_q;

endmodule

// File: tb/tb_demux_router_8ch.sv
// Bench for demux_router_8ch: scoreboard of expected output beats
// plus per-scenario timing checks.
module tb_demux_router_8ch;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [2:0]        in_dest;
  logic              in_last;
  logic              cfg_rr;
  logic [7:0]        ch_en;
  logic [7:0]        out_valid;
  logic [7:0]        out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [7:0]        drop_cnt;
  logic              busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [16:0] exp_q[$];
  logic [2:0]  m_rr_ptr;
  int          m_drop;

  always #5 clk = ~clk;

  demux_router_8ch #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dest  (in_dest),
    .in_last  (in_last),
    .cfg_rr   (cfg_rr),
    .ch_en    (ch_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  // Output-side scoreboard: pop on every completed output transfer.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst && |(out_valid & out_ready)) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected got v=%h d=%h l=%b none expected",
                 out_valid, out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_last, out_valid, out_data} !== e)
          $display("FAIL sb_beat got l=%b v=%h d=%h exp l=%b v=%h d=%h",
                   out_last, out_valid, out_data, e[16], e[15:8], e[7:0]);
        else
          pass_cnt++;
      end
    end
  end

  task automatic model_head(input logic [2:0] dest, input logic rr,
                            input logic [7:0] en, output logic ok,
                            output logic [2:0] ch);
    logic [2:0] idx;
    ok = 1'b0;
    ch = 3'd0;
    if (rr) begin
      for (int i = 0; i < 8; i++) begin
        idx = m_rr_ptr + 3'(i);
        if (!ok && en[idx]) begin
          ok = 1'b1;
          ch = idx;
        end
      end
      if (ok) m_rr_ptr = ch + 3'd1;
    end else begin
      ok = en[dest];
      ch = dest;
    end
    if (!ok && m_drop < 255) m_drop++;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    int budget;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    budget   = 0;
    @(negedge clk);
    while (!in_ready && budget < 100) begin
      budget++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL send_timeout in_ready=%b exp 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [2:0] dest, input int n,
                          input logic [7:0] base,
                          output logic ok, output logic [2:0] ch);
    logic [2:0] sv_dest;
    logic [7:0] sv_en;
    logic       sv_rr;
    sv_dest = dest;
    sv_en   = ch_en;
    sv_rr   = cfg_rr;
    in_dest = dest;
    model_head(dest, cfg_rr, ch_en, ok, ch);
    for (int b = 0; b < n; b++) begin
      if (b > 0) begin
        in_dest = 3'($urandom);
        ch_en   = 8'($urandom);
        cfg_rr  = 1'($urandom);
      end
      if (ok)
        exp_q.push_back({(b == n - 1), 8'h01 << ch, base + 8'(b)});
      send_beat(base + 8'(b), (b == n - 1));
    end
    in_dest = sv_dest;
    ch_en   = sv_en;
    cfg_rr  = sv_rr;
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      @(posedge clk);
      budget++;
    end
    #1;
    total_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL drain_timeout left=%0d exp 0", exp_q.size());
    else
      pass_cnt++;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    m_rr_ptr = 3'd0;
    m_drop   = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({out_valid, out_data, out_last, drop_cnt, busy, in_ready} !==
        {8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1})
      $display("FAIL reset_state got v=%h d=%h l=%b dc=%h b=%b r=%b",
               out_valid, out_data, out_last, drop_cnt, busy, in_ready);
    else
      pass_cnt++;
  endtask

  task automatic test_dest_route();
    logic [7:0] exp_v[3] = '{8'h20, 8'h20, 8'h20};
    logic       ok;
    logic [2:0] ch;
    cfg_rr    = 1'b0;
    ch_en     = 8'hFF;
    out_ready = 8'hFF;
    in_dest   = 3'd5;
    model_head(3'd5, 1'b0, 8'hFF, ok, ch);
    for (int b = 0; b < 3; b++) begin
      exp_q.push_back({(b == 2), 8'h20, 8'h50 + 8'(b)});
      send_beat(8'h50 + 8'(b), (b == 2));
      total_cnt++;
      if (out_valid !== exp_v[b] || out_last !== (b == 2))
        $display("FAIL dest_timing beat%0d got v=%h l=%b exp v=%h l=%b",
                 b, out_valid, out_last, exp_v[b], (b == 2));
      else
        pass_cnt++;
    end
    wait_drain();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_ch[5] = '{3'd2, 3'd5, 3'd7, 3'd2, 3'd5};
    logic       ok;
    logic [2:0] ch;
    cfg_rr    = 1'b1;
    ch_en     = 8'b1010_0100;
    out_ready = 8'hFF;
    for (int p = 0; p < 5; p++) begin
      send_pkt(3'd0, 1, 8'h70 + 8'(p), ok, ch);
      total_cnt++;
      if (out_valid !== (8'h01 << exp_ch[p]))
        $display("FAIL rr_grant pkt%0d got v=%h exp v=%h",
                 p, out_valid, 8'h01 << exp_ch[p]);
      else
        pass_cnt++;
    end
    wait_drain();
    cfg_rr = 1'b0;
  endtask

  task automatic test_drop();
    logic       ok;
    logic [2:0] ch;
    do_reset();
    cfg_rr    = 1'b0;
    ch_en     = 8'hF7;
    out_ready = 8'hFF;
    in_dest   = 3'd3;
    model_head(3'd3, 1'b0, 8'hF7, ok, ch);
    for (int b = 0; b < 2; b++) begin
      if (b == 1) ch_en = 8'hFF;
      send_beat(8'hA0 + 8'(b), (b == 1));
      total_cnt++;
      if (out_valid !== 8'h00)
        $display("FAIL drop_valid beat%0d got v=%h exp 00", b, out_valid);
      else
        pass_cnt++;
    end
    ch_en = 8'hF7;
    total_cnt++;
    if (drop_cnt !== 8'd1)
      $display("FAIL drop_once got %0d exp 1", drop_cnt);
    else
      pass_cnt++;
    for (int p = 0; p < 256; p++)
      send_pkt(3'd3, 1, 8'(p), ok, ch);
    total_cnt++;
    if (drop_cnt !== 8'(m_drop) || drop_cnt !== 8'd255)
      $display("FAIL drop_sat got %0d exp %0d", drop_cnt, m_drop);
    else
      pass_cnt++;
    ch_en = 8'hFF;
    send_pkt(3'd4, 2, 8'hC0, ok, ch);
    wait_drain();
  endtask

  task automatic test_stall();
    logic       ok;
    logic [2:0] ch;
    cfg_rr    = 1'b0;
    ch_en     = 8'hFF;
    out_ready = 8'hFD;
    in_dest   = 3'd1;
    model_head(3'd1, 1'b0, 8'hFF, ok, ch);
    exp_q.push_back({1'b0, 8'h02, 8'h10});
    send_beat(8'h10, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h11;
    in_last  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      total_cnt++;
      if ({in_ready, out_valid, out_data} !== {1'b0, 8'h02, 8'h10})
        $display("FAIL stall_hold got r=%b v=%h d=%h exp r=0 v=02 d=10",
                 in_ready, out_valid, out_data);
      else
        pass_cnt++;
      @(posedge clk);
      #1;
    end
    out_ready = 8'hFF;
    for (int b = 1; b < 4; b++) begin
      exp_q.push_back({(b == 3), 8'h02, 8'h10 + 8'(b)});
      send_beat(8'h10 + 8'(b), (b == 3));
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_v[4] = '{8'h01, 8'h01, 8'h40, 8'h40};
    logic       ok;
    logic [2:0] ch;
    cfg_rr    = 1'b0;
    ch_en     = 8'hFF;
    out_ready = 8'hFF;
    for (int p = 0; p < 2; p++) begin
      in_dest = (p == 0) ? 3'd0 : 3'd6;
      model_head(in_dest, 1'b0, 8'hFF, ok, ch);
      for (int b = 0; b < 2; b++) begin
        exp_q.push_back({(b == 1), exp_v[p*2+b], 8'hB0 + 8'(p*2+b)});
        send_beat(8'hB0 + 8'(p*2+b), (b == 1));
        total_cnt++;
        if (out_valid !== exp_v[p*2+b])
          $display("FAIL b2b_valid beat%0d got v=%h exp v=%h",
                   p*2+b, out_valid, exp_v[p*2+b]);
        else
          pass_cnt++;
      end
    end
    wait_drain();
  endtask

  task automatic test_mid_reset();
    logic       ok;
    logic [2:0] ch;
    cfg_rr    = 1'b0;
    ch_en     = 8'hFF;
    out_ready = 8'h00;
    in_dest   = 3'd4;
    send_beat(8'hD0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_rr_ptr = 3'd0;
    m_drop   = 0;
    total_cnt++;
    if ({out_valid, busy} !== {8'h00, 1'b0})
      $display("FAIL mid_reset got v=%h b=%b exp v=00 b=0",
               out_valid, busy);
    else
      pass_cnt++;
    out_ready = 8'hFF;
    send_pkt(3'd2, 1, 8'hE0, ok, ch);
    total_cnt++;
    if ({out_valid, out_last, out_data} !== {8'h04, 1'b1, 8'hE0})
      $display("FAIL post_reset_head got v=%h l=%b d=%h exp v=04 l=1 d=e0",
               out_valid, out_last, out_data);
    else
      pass_cnt++;
    wait_drain();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dest   = 3'd0;
    in_last   = 1'b0;
    cfg_rr    = 1'b0;
    ch_en     = 8'hFF;
    out_ready = 8'hFF;
    m_rr_ptr  = 3'd0;
    m_drop    = 0;
    test_reset();
    test_dest_route();
    test_round_robin();
    test_drop();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/demux_router_8ch.md
DEMUX_ROUTER_8CH -- requirements
Module: demux_router_8ch

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter: DATA_W, 8, beat data width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  source beat valid.
REQ-006 in_ready  output  1  router accepts beat this cycle (comb).
REQ-007 in_data  input  DATA_W  beat payload.
REQ-008 in_dest  input  3  destination channel, sampled on head beat only.
REQ-009 in_last  input  1  final beat of packet.
REQ-010 cfg_rr  input  1  1 = round-robin routing; 0 = in_dest routing; sampled on head beat only.
REQ-011 ch_en  input  8  per-channel enable; sampled on head beat only.
REQ-012 out_valid  output  8  one-hot valid toward selected channel; all-zero when idle.
REQ-013 out_ready  input  8  per-channel sink ready.
REQ-014 out_data  output  DATA_W  shared data bus, registered.
REQ-015 out_last  output  1  registered last flag.
REQ-016 drop_cnt  output  8  dropped-packet count, saturating.
REQ-017 busy  output  1  high when state != IDLE or output buffer occupied.

Function
REQ-018 Transfer on input SHALL occur when in_valid & in_ready; transfer on output when obuf_v & out_ready[sel_q].
REQ-019 Block SHALL hold a single output buffer (obuf_v, data, last) plus 3-bit sel_q; out_valid = obuf_v ? (1 << sel_q) : 8'h00.
REQ-020 in_ready SHALL equal (state==DROP) | ~obuf_v | out_ready[sel_q]; accepted beat appears at outputs the next cycle (latency 1).
REQ-021 FSM states SHALL be IDLE (await head beat), PASS (forward body beats to sel_q), DROP (accept and discard body beats).
REQ-022 Head beat in IDLE, cfg_rr=0: if ch_en[in_dest]=1, load obuf, sel_q<=in_dest; else discard.
REQ-023 Head beat in IDLE, cfg_rr=1: grant first channel c with ch_en[c]=1 searching rr_ptr, rr_ptr+1, ... modulo 8; load obuf, sel_q<=c, rr_ptr<=c+1 mod 8; if ch_en==0, discard.
REQ-024 rr_ptr SHALL change only on a round-robin grant.
REQ-025 Loaded head beat with in_last=0 -> PASS; with in_last=1 -> remain IDLE (single-beat packet).
REQ-026 Discarded head beat SHALL increment drop_cnt (saturate at 255, no wrap); in_last=0 -> DROP, in_last=1 -> remain IDLE.
REQ-027 PASS: each accepted beat loads obuf to unchanged sel_q; accepted beat with in_last=1 -> IDLE.
REQ-028 DROP: each accepted beat discarded, obuf untouched; in_last=1 -> IDLE; drop_cnt not incremented again.
REQ-029 Changes on cfg_rr, ch_en, in_dest during a packet SHALL have no effect until the next head beat.
REQ-030 Simultaneous output drain and input accept SHALL keep obuf_v=1 with new beat (no bubble); sel_q updates only when the new beat loads obuf.
REQ-031 obuf contents, out_data, out_last SHALL remain stable while obuf_v=1 and out_ready[sel_q]=0.
REQ-032 A discarded head beat SHALL not disturb obuf, which continues draining the previous packet's last beat to its channel.

Reset
REQ-033 On rst=1 at a clock edge: state<=IDLE, obuf_v<=0, out_valid=0, out_data<=0, out_last<=0, sel_q<=0, rr_ptr<=0, drop_cnt<=0; busy=0 next cycle.
REQ-034 Reset mid-packet SHALL discard the buffered beat and packet state; the first beat after reset is treated as a head beat.

Verification
REQ-035 cfg_rr=0, ch_en=8'hFF, 3-beat packet dest=5, out_ready=8'hFF -> out_valid=8'h20 for 3 consecutive cycles starting 1 cycle after first accept, out_last on third.
REQ-036 cfg_rr=1, ch_en=8'b1010_0100, four 1-beat packets -> granted channels 2,5,7,2; rr_ptr=3 after last.
REQ-037 cfg_rr=0, ch_en[3]=0, 2-beat packet dest=3 -> both beats accepted, out_valid stays 0, drop_cnt 0->1; then 256 more dropped packets -> drop_cnt=255.
REQ-038 out_ready[1]=0 for 4 cycles during packet to ch1 -> in_ready=0 with obuf full, out_data stable, no beat lost or duplicated after release.
REQ-039 Back-to-back packets to ch0 then ch6 with out_ready all 1 -> no idle cycle between last beat on ch0 and head beat on ch6.
REQ-040 rst asserted in PASS with obuf_v=1 -> next cycle out_valid=0, busy=0, next beat routed as head beat.
